// File: rtl/shift_unit.sv
// shift_unit: multi-cycle barrel-free shifter.
// The unit accepts one request in IDLE and shifts a working register by up
// to STEP positions per cycle in SHIFT. It then holds the result in DONE
// until the consumer takes it.
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  input  logic [1:0]               i_mode,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] STEP_MAX  = SHW'(STEP);
  localparam logic [SHW:0]   WIDTH_EXT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;

  state_t           state;
  mode_t            mode_q;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   remaining;
  logic [SHW-1:0]   step_k;
  logic [SHW:0]     rot_amt;
  logic [WIDTH-1:0] shifted;

  assign o_result = work;

  // Positions to move this cycle: the smaller of what is left and STEP.
  always_comb begin
    step_k = (remaining < STEP_MAX) ? remaining : STEP_MAX;
  end

  // One partial shift of the working register in the captured mode.
  // The arithmetic fill uses the working register's MSB. That bit keeps the
  // captured sign across every partial step.
  always_comb begin
    rot_amt = WIDTH_EXT - {1'b0, step_k};
    shifted = work;
    case (mode_q)
      MODE_LSL: shifted = work << step_k;
      MODE_LSR: shifted = work >> step_k;
      MODE_ASR: shifted = $signed(work) >>> step_k;
      MODE_ROR: shifted = (work >> step_k) | (work << rot_amt);
      default:  shifted = work;
    endcase
  end

  // Control FSM with registered handshake and busy outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      mode_q    <= MODE_LSL;
      work      <= '0;
      remaining <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work      <= i_data;
            mode_q    <= mode_t'(i_mode);
            remaining <= i_shamt;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            if (i_shamt == '0) begin
              state   <= DONE;
              o_valid <= 1'b1;
            end else begin
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= shifted;
          remaining <= remaining - step_k;
          if (remaining == step_k) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed and randomized checks of shift_unit.
// The randomized part drives nine width/step configurations. It compares
// each one against a transaction-level reference model.
module tb_shift_unit;

  localparam int NCFG = 9;

  // Configuration table shared by the generate block and the model.
  function automatic int cfg_w(input int g);
    return (g < 3) ? 8 : (g < 6) ? 16 : 32;
  endfunction

  function automatic int cfg_s(input int g);
    int w;
    w = cfg_w(g);
    return (g % 3 == 0) ? 1 : (g % 3 == 1) ? 3 : w - 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Directed instances: index 0 is WIDTH=8 STEP=1, index 1 is WIDTH=8 STEP=2.
  logic       d_rst;
  logic [1:0] d_valid;
  logic [1:0] d_ready;
  logic [7:0] d_data;
  logic [2:0] d_shamt;
  logic [1:0] d_mode;
  logic [1:0] d_or;
  logic [1:0] d_ov;
  logic [1:0] d_busy;
  logic [7:0] d_res [2];

  shift_unit #(.WIDTH(8), .STEP(1)) dut_s1 (
    .i_clk(clk), .i_rst(d_rst), .i_valid(d_valid[0]), .o_ready(d_or[0]),
    .i_data(d_data), .i_shamt(d_shamt), .i_mode(d_mode), .o_valid(d_ov[0]),
    .i_ready(d_ready[0]), .o_result(d_res[0]), .o_busy(d_busy[0])
  );

  shift_unit #(.WIDTH(8), .STEP(2)) dut_s2 (
    .i_clk(clk), .i_rst(d_rst), .i_valid(d_valid[1]), .o_ready(d_or[1]),
    .i_data(d_data), .i_shamt(d_shamt), .i_mode(d_mode), .o_valid(d_ov[1]),
    .i_ready(d_ready[1]), .o_result(d_res[1]), .o_busy(d_busy[1])
  );

  // Randomized instances share the data inputs. Each one has its own handshake.
  logic            r_rst;
  logic [31:0]     r_data;
  logic [4:0]      r_shamt;
  logic [1:0]      r_mode;
  logic [NCFG-1:0] r_valid;
  logic [NCFG-1:0] r_ready;
  logic [NCFG-1:0] r_oready;
  logic [NCFG-1:0] r_ovalid;
  logic [NCFG-1:0] r_obusy;
  logic [31:0]     r_res [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_rnd
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    logic [W-1:0] res;
    shift_unit #(.WIDTH(W), .STEP(S)) dut (
      .i_clk(clk), .i_rst(r_rst), .i_valid(r_valid[g]), .o_ready(r_oready[g]),
      .i_data(r_data[W-1:0]), .i_shamt(r_shamt[$clog2(W)-1:0]), .i_mode(r_mode),
      .o_valid(r_ovalid[g]), .i_ready(r_ready[g]), .o_result(res), .o_busy(r_obusy[g])
    );
    assign r_res[g] = 32'(res);
  end

  // Reference model state: phase 0 idle, 1 working, 2 result held.
  int          m_phase [NCFG];
  int          m_left  [NCFG];
  logic [31:0] m_exp   [NCFG];

  // Single-shot shift of a w-bit value, computed with plain integer arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input logic [1:0] mode, input int w);
    longint unsigned mask;
    longint unsigned x;
    longint unsigned r;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    case (mode)
      2'b00: r = (x << sh) & mask;
      2'b01: r = x >> sh;
      2'b10: begin
        r = x >> sh;
        if (((x >> (w - 1)) & 64'd1) != 64'd0) r = r | (mask & ~(mask >> sh));
      end
      default: r = ((x >> sh) | (x << (w - sh))) & mask;
    endcase
    return r[31:0];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request to a directed instance.
  // The task returns at the falling edge right after the accepting edge.
  // It then scrambles the operand inputs so later changes are visible if captured.
  task automatic apply_stimulus(input int sel, input logic [7:0] data,
                                input logic [2:0] shamt, input logic [1:0] mode);
    @(negedge clk);
    d_data       = data;
    d_shamt      = shamt;
    d_mode       = mode;
    d_valid[sel] = 1'b1;
    @(negedge clk);
    d_valid[sel] = 1'b0;
    d_data       = ~data;
    d_shamt      = ~shamt;
    d_mode       = ~mode;
  endtask

  // Count edges from acceptance (the accepting edge is edge 1) until o_valid.
  task automatic wait_valid(input int sel, input bit chk_busy, output int edges);
    edges = 1;
    while (d_ov[sel] !== 1'b1 && edges < 40) begin
      if (chk_busy) check_output("busy_while_shifting", 32'(d_busy[sel]), 32'd1);
      @(negedge clk);
      edges++;
    end
    if (chk_busy) check_output("busy_in_done", 32'(d_busy[sel]), 32'd1);
  endtask

  logic [7:0] exp_033 [4] = '{8'hB0, 8'h12, 8'hF2, 8'hD2};

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   edges;
    int   n;
    int   sh;
    int   w;
    logic [31:0] xres;

    d_rst = 1'b1; d_valid = '0; d_ready = 2'b11;
    d_data = '0; d_shamt = '0; d_mode = '0;
    r_rst = 1'b1; r_valid = '0; r_ready = '0;
    r_data = '0; r_shamt = '0; r_mode = '0;
    for (int g = 0; g < NCFG; g++) begin
      m_phase[g] = 0; m_left[g] = 0; m_exp[g] = '0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_output("rst_ready", 32'(d_or[s]), 32'd1);
      check_output("rst_valid", 32'(d_ov[s]), 32'd0);
      check_output("rst_busy", 32'(d_busy[s]), 32'd0);
      check_output("rst_result", 32'(d_res[s]), 32'd0);
    end
    for (int g = 0; g < NCFG; g++) begin
      check_output($sformatf("rnd%0d_rst_result", g), r_res[g], 32'd0);
      check_output($sformatf("rnd%0d_rst_ready", g), 32'(r_oready[g]), 32'd1);
    end
    d_rst = 1'b0;
    r_rst = 1'b0;

    // Operand 0x96 shifted by 3 in every mode, STEP=1.
    for (int m = 0; m < 4; m++) begin
      apply_stimulus(0, 8'h96, 3'd3, 2'(m));
      wait_valid(0, 1'b0, edges);
      check_output($sformatf("x96_mode%0d_latency", m), 32'(edges), 32'd4);
      check_output($sformatf("x96_mode%0d_result", m), 32'(d_res[0]), 32'(exp_033[m]));
      @(negedge clk);
      check_output("x96_valid_one_cycle", 32'(d_ov[0]), 32'd0);
      check_output("x96_ready_after", 32'(d_or[0]), 32'd1);
    end

    // Zero shift amount passes the operand straight through.
    for (int m = 0; m < 4; m++) begin
      apply_stimulus(0, 8'h5A, 3'd0, 2'(m));
      wait_valid(0, 1'b0, edges);
      check_output($sformatf("zero_mode%0d_latency", m), 32'(edges), 32'd1);
      check_output($sformatf("zero_mode%0d_result", m), 32'(d_res[0]), 32'h5A);
      @(negedge clk);
    end

    // STEP=2: shift by 7 takes four shift cycles, so there are five edges in total.
    apply_stimulus(1, 8'h01, 3'd7, 2'b00);
    wait_valid(1, 1'b1, edges);
    check_output("step2_latency", 32'(edges), 32'd5);
    check_output("step2_result", 32'(d_res[1]), 32'h80);
    @(negedge clk);

    // Backpressure holds the result. Release must not accept a request on the same edge.
    d_ready[0] = 1'b0;
    apply_stimulus(0, 8'h96, 3'd3, 2'b11);
    wait_valid(0, 1'b0, edges);
    check_output("bp_latency", 32'(edges), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("bp_valid_hold", 32'(d_ov[0]), 32'd1);
      check_output("bp_result_hold", 32'(d_res[0]), 32'hD2);
      check_output("bp_ready_low", 32'(d_or[0]), 32'd0);
    end
    d_ready[0] = 1'b1;
    d_valid[0] = 1'b1;
    d_data     = 8'h3C;
    d_shamt    = 3'd0;
    d_mode     = 2'b00;
    @(negedge clk);
    check_output("bp_release_valid", 32'(d_ov[0]), 32'd0);
    check_output("bp_release_ready", 32'(d_or[0]), 32'd1);
    @(negedge clk);
    d_valid[0] = 1'b0;
    check_output("bp_next_valid", 32'(d_ov[0]), 32'd1);
    check_output("bp_next_result", 32'(d_res[0]), 32'h3C);
    @(negedge clk);

    // Reset in the middle of SHIFT abandons the operation.
    apply_stimulus(0, 8'hC3, 3'd6, 2'b00);
    repeat (2) @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    d_rst = 1'b0;
    check_output("midrst_busy", 32'(d_busy[0]), 32'd0);
    check_output("midrst_valid", 32'(d_ov[0]), 32'd0);
    check_output("midrst_ready", 32'(d_or[0]), 32'd1);
    check_output("midrst_result", 32'(d_res[0]), 32'd0);
    apply_stimulus(0, 8'hC3, 3'd6, 2'b11);
    wait_valid(0, 1'b0, edges);
    check_output("postrst_latency", 32'(edges), 32'd7);
    check_output("postrst_result", 32'(d_res[0]), 32'h0F);
    @(negedge clk);

    // Randomized traffic on all nine configurations against the reference model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        check_output($sformatf("rnd%0d_ready", g), 32'(r_oready[g]), 32'(m_phase[g] == 0));
        check_output($sformatf("rnd%0d_valid", g), 32'(r_ovalid[g]), 32'(m_phase[g] == 2));
        check_output($sformatf("rnd%0d_busy", g), 32'(r_obusy[g]), 32'(m_phase[g] != 0));
        if (m_phase[g] == 2)
          check_output($sformatf("rnd%0d_result", g), r_res[g], m_exp[g]);
      end
      r_rst   = ($urandom_range(0, 149) == 0);
      r_data  = $urandom;
      r_shamt = 5'($urandom);
      r_mode  = 2'($urandom);
      for (int g = 0; g < NCFG; g++) begin
        r_valid[g] = 1'($urandom_range(0, 1));
        r_ready[g] = ($urandom_range(0, 3) != 0);
      end
      // Predict the state each configuration reaches on the coming edge.
      for (int g = 0; g < NCFG; g++) begin
        w = cfg_w(g);
        if (r_rst) begin
          m_phase[g] = 0;
          m_left[g]  = 0;
        end else if (m_phase[g] == 0) begin
          if (r_valid[g]) begin
            sh   = int'(r_shamt) % w;
            xres = ref_shift(r_data, sh, r_mode, w);
            m_exp[g] = xres;
            n = (sh + cfg_s(g) - 1) / cfg_s(g);
            if (n == 0) m_phase[g] = 2;
            else begin
              m_phase[g] = 1;
              m_left[g]  = n;
            end
          end
        end else if (m_phase[g] == 1) begin
          m_left[g]--;
          if (m_left[g] == 0) m_phase[g] = 2;
        end else begin
          if (r_ready[g]) m_phase[g] = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=2).
REQ-002 SHALL have parameter STEP, default 1, maximum bit positions shifted per cycle (1..WIDTH-1).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port i_valid  input  1  request valid.
REQ-007 SHALL have port o_ready  output  1  unit can accept a request.
REQ-008 SHALL have port i_data  input  WIDTH  operand.
REQ-009 SHALL have port i_shamt  input  $clog2(WIDTH)  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port i_mode  input  2  operation: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-011 SHALL have port o_valid  output  1  result valid.
REQ-012 SHALL have port i_ready  input  1  consumer accepts result.
REQ-013 SHALL have port o_result  output  WIDTH  shifted result.
REQ-014 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL drive o_ready high only in IDLE; o_valid high only in DONE.
REQ-017 SHALL accept a request on an edge where state is IDLE and i_valid=1, capturing i_data, i_shamt, i_mode into internal registers.
REQ-018 SHALL ignore i_data/i_shamt/i_mode changes after acceptance until the next acceptance.
REQ-019 SHALL, on accept with i_shamt=0, go to DONE with o_result=i_data.
REQ-020 SHALL, on accept with i_shamt>0, go to SHIFT with remaining count = i_shamt.
REQ-021 SHALL, each SHIFT edge, shift the working register by k = min(remaining, STEP) in the captured mode and decrement remaining by k.
REQ-022 SHALL go from SHIFT to DONE on the edge where remaining reaches 0.
REQ-023 SHALL therefore assert o_valid exactly 1 + ceil(shamt/STEP) edges after the accepting edge.
REQ-024 SHALL fill vacated bits with 0 for logical modes, with the captured MSB for arithmetic right, and with bits shifted out of bit 0 for rotate right.
REQ-025 SHALL produce a final result identical to a single-step shift by shamt, for every STEP.
REQ-026 SHALL hold o_result and o_valid stable in DONE while i_ready=0.
REQ-027 SHALL return from DONE to IDLE on the edge where i_ready=1; no new request accepted on that same edge.
REQ-028 SHALL keep o_result at the last result value in IDLE and SHIFT states only via the working register; o_result is meaningful only while o_valid=1.
REQ-029 SHALL ignore i_ready outside DONE and i_valid outside IDLE.

Reset
REQ-030 SHALL, on any edge with i_rst=1, enter IDLE regardless of state, abandoning any operation in progress.
REQ-031 SHALL have reset values o_ready=1, o_valid=0, o_busy=0, o_result=0, remaining count=0.
REQ-032 SHALL give i_rst priority over accept and over i_ready on the same edge.

Verification
REQ-033 SHALL cover WIDTH=8, STEP=1, i_data=0x96, i_shamt=3, i_ready=1: mode 00 -> 0xB0, 01 -> 0x12, 10 -> 0xF2, 11 -> 0xD2, each with o_valid 4 edges after accept for one cycle.
REQ-034 SHALL cover i_shamt=0, i_data=0x5A, any mode -> o_result=0x5A, o_valid 1 edge after accept.
REQ-035 SHALL cover WIDTH=8, STEP=2, i_data=0x01, i_shamt=7, mode 00 -> o_result=0x80, o_valid 5 edges after accept, o_busy high for those 5 edges.
REQ-036 SHALL cover backpressure: i_ready=0 for 10 cycles in DONE -> o_valid and o_result constant, o_ready=0; i_ready=1 -> IDLE next edge, o_ready=1.
REQ-037 SHALL cover reset mid-SHIFT (STEP=1, shamt=6, i_rst after 2 shift edges) -> next edge o_busy=0, o_valid=0, o_ready=1, o_result=0; subsequent request completes correctly.
REQ-038 SHALL cover randomized requests for WIDTH in {8,16,32}, STEP in {1,3,WIDTH-1}, all modes, compared against a reference model with random i_valid/i_ready.
